// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte requesters onto one uart transmitter, with a watchdog on tx_busy.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_send,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         active,
    output logic                         tx_timeout
);
    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                 state_q;
    logic                   tx_send_q;
    logic                   tx_timeout_q;
    logic [DATA_BITS-1:0]   tx_data_q;
    logic [GW-1:0]          grant_id_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;

    logic                   found;
    logic                   grant;
    logic [GW-1:0]          win_idx;
    logic [GW-1:0]          cand;
    int unsigned            rr_idx;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        rr_idx  = 0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = GW'(i);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
`else
        // Search starts one past the last winner and wraps back to 0.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx = 32'(grant_id_q) + i;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            cand = GW'(rr_idx);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
`endif
    end

    assign grant = reset_n && (state_q == IDLE) && !tx_busy && found;

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (win_idx == GW'(i));
        end
    end

    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tx_send_q    <= 1'b0;
            tx_timeout_q <= 1'b0;
            tx_data_q    <= '0;
            grant_id_q   <= GW'(NUM_REQ - 1);
            cnt_q        <= '0;
        end else begin
            tx_send_q    <= 1'b0;
            tx_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        tx_data_q  <= req_data[win_idx*DATA_BITS +: DATA_BITS];
                        grant_id_q <= win_idx;
                        tx_send_q  <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_d == CW'(BUSY_TIMEOUT)) begin
                        tx_timeout_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_send    = tx_send_q;
    assign tx_timeout = tx_timeout_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_id_q;
    assign active     = reset_n && (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued by the stimulus
// and popped by a monitor on every tx_send pulse.
module tb_uart_tx_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        tx_timeout;

    logic        uart_en;
    logic        ext_busy;
    int          busy_cnt = 0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sends = 0;
    int tos   = 0;
    int send_cyc = 0;
    int to_cyc   = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_BITS(8),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_send(tx_send),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .tx_timeout(tx_timeout)
    );

    // Uart model: busy for 10 cycles starting the cycle after tx_send; ignores arbiter reset.
    always @(posedge clock) begin
        if (tx_send && uart_en) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || ext_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (tx_send) begin
            exp_t e;
            sends++;
            send_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_send", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("send_data", 32'(tx_data), 32'(e.data));
                check("send_grant_id", 32'(grant_id), 32'(e.id));
            end
        end
        if (tx_timeout) begin
            tos++;
            to_cyc = cyc;
        end
        if (active) check("ready_zero_when_active", 32'(req_ready), 0);
    end

    task automatic send_one(input logic [3:0] mask, input int budget,
                            input logic [3:0] exp_ready, output int waited);
        req_valid = mask;
        waited = 0;
        while (waited < budget) begin
            @(negedge clock);
            if (|(req_valid & req_ready)) break;
            waited++;
        end
        if (waited >= budget) check("accept_timeout", 0, 1);
        else check("ready_value", 32'(req_ready), 32'(exp_ready));
        @(posedge clock);
        #1 req_valid = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (active && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", 32'(active), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        int acc;
        int n;
        int t0;
        int s0;
        reset_n   = 1'b0;
        uart_en   = 1'b1;
        ext_busy  = 1'b0;
        req_valid = '1;
        req_data  = {8'h3C, 8'hA5, 8'h5A, 8'hC3};

        // Reset state, with requests pending and uart idle.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_active", 32'(active), 0);
        check("rst_tx_send", 32'(tx_send), 0);
        check("rst_tx_timeout", 32'(tx_timeout), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant_id", 32'(grant_id), 3);
        @(posedge clock);
        #1 req_valid = '0;
        reset_n = 1'b1;

        // Single request from requester 2.
        exp_q.push_back('{2, 8'hA5});
        send_one(4'b0100, 20, 4'b0100, w);
        check("single_grant_same_cycle", 32'(w), 0);
        wait_idle(40);
        check("single_busy_low_at_idle", 32'(tx_busy), 0);
        check("single_grant_id", 32'(grant_id), 2);
        check("single_tx_data_stable", 32'(tx_data), 32'hA5);

        // All four requesting for eight transfers.
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) exp_q.push_back('{0, 8'hC3});
`else
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{0, 8'hC3});
            exp_q.push_back('{1, 8'h5A});
            exp_q.push_back('{2, 8'hA5});
            exp_q.push_back('{3, 8'h3C});
        end
`endif
        req_valid = '1;
        acc = 0;
        n = 0;
        while (acc < 8 && n < 400) begin
            @(negedge clock);
            n++;
            if (|(req_valid & req_ready)) acc++;
        end
        @(posedge clock);
        #1 req_valid = '0;
        check("fair_accepts", 32'(acc), 8);
        wait_idle(40);

        // Busy never rises: watchdog fires after four WAIT_BUSY cycles.
        uart_en = 1'b0;
        t0 = tos;
        s0 = sends;
        exp_q.push_back('{1, 8'h5A});
        send_one(4'b0010, 20, 4'b0010, w);
        wait_idle(40);
        check("timeout_pulses", 32'(tos - t0), 1);
        check("timeout_single_send", 32'(sends - s0), 1);
        check("timeout_latency", 32'(to_cyc - send_cyc), 5);
        uart_en = 1'b1;

        // Reset while waiting for the uart to finish.
        exp_q.push_back('{3, 8'h3C});
        send_one(4'b1000, 20, 4'b1000, w);
        repeat (4) @(posedge clock);
        #1;
        exp_q.push_back('{0, 8'hC3});
        reset_n   = 1'b0;
        req_valid = '1;
        @(negedge clock);
        check("midrst_active", 32'(active), 0);
        check("midrst_ready", 32'(req_ready), 0);
        check("midrst_busy_inflight", 32'(tx_busy), 1);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("midrst_tx_send", 32'(tx_send), 0);
        check("midrst_tx_data", 32'(tx_data), 0);
        check("midrst_grant_id", 32'(grant_id), 3);
        n = 0;
        while (tx_busy && n < 50) begin
            check("midrst_ready_blocked", 32'(req_ready), 0);
            @(negedge clock);
            n++;
        end
        check("midrst_ready_after_busy", 32'(req_ready), 32'b0001);
        @(posedge clock);
        #1 req_valid = '0;
        wait_idle(40);

        // Foreign busy in IDLE holds off the grant.
        ext_busy  = 1'b1;
        req_valid = 4'b0001;
        repeat (5) begin
            @(negedge clock);
            check("foreign_busy_ready", 32'(req_ready), 0);
        end
        @(posedge clock);
        #1 ext_busy = 1'b0;
        exp_q.push_back('{0, 8'hC3});
        send_one(4'b0001, 20, 4'b0001, w);
        check("foreign_grant_next_cycle", 32'(w), 0);
        wait_idle(40);

        repeat (3) @(posedge clock);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
